// File: rtl/hlsm_batch_sequencer.sv
// Batch sequencer: queues operand sets and runs one Start/Done kernel job per set, returning {z,x} in order.
// Optional watchdog on the kernel wait, enabled with `define HLSM_TIMEOUT_EN.
module hlsm_batch_sequencer #(
  parameter int unsigned DW        = 16,
  parameter int unsigned ZW        = 8,
  parameter int unsigned XW        = 16,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TO_CYCLES = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_a_i,
  input  logic [DW-1:0] in_b_i,
  input  logic [DW-1:0] in_c_i,
  output logic          k_rst_o,
  output logic          k_start_o,
  output logic [DW-1:0] k_a_o,
  output logic [DW-1:0] k_b_o,
  output logic [DW-1:0] k_c_o,
  input  logic          k_done_i,
  input  logic [ZW-1:0] k_z_i,
  input  logic [XW-1:0] k_x_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [ZW-1:0] out_z_o,
  output logic [XW-1:0] out_x_o,
  output logic          busy_o,
  output logic [15:0]   batch_cnt_o,
  output logic          timeout_err_o
);

  localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned EW  = 3 * DW;

  typedef enum logic [2:0] {
    S_IDLE, S_KRST, S_START, S_WAIT, S_HOLD
  } state_e;

  state_e          state_q;
  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            full, push, pop;
  logic            k_rst_q, k_start_q, out_valid_q, busy_q;
  logic [DW-1:0]   k_a_q, k_b_q, k_c_q;
  logic [ZW-1:0]   out_z_q;
  logic [XW-1:0]   out_x_q;
  logic [15:0]     batch_cnt_q;

  assign full       = (count_q == CW'(DEPTH));
  assign in_ready_o = ~full & ~rst_i;
  assign push       = in_valid_i & in_ready_o;
  assign pop        = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Operand FIFO; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_a_i, in_b_i, in_c_i};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

`ifdef HLSM_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TO_CYCLES + 1);
  logic [WDW-1:0] wd_q;
  logic           timeout_err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^32'(TO_CYCLES);
`endif

  // Job sequencing FSM with registered strobes and result capture
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      k_rst_q     <= 1'b0;
      k_start_q   <= 1'b0;
      k_a_q       <= '0;
      k_b_q       <= '0;
      k_c_q       <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_x_q     <= '0;
      busy_q      <= 1'b0;
      batch_cnt_q <= '0;
`ifdef HLSM_TIMEOUT_EN
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      k_rst_q   <= 1'b0;
      k_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            {k_a_q, k_b_q, k_c_q} <= mem_q[rd_ptr_q];
            k_rst_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_KRST;
          end
        end
        S_KRST: begin
          k_start_q <= 1'b1;
          state_q   <= S_START;
        end
        S_START: begin
`ifdef HLSM_TIMEOUT_EN
          wd_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (k_done_i) begin
            out_z_q     <= k_z_i;
            out_x_q     <= k_x_i;
            out_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
`ifdef HLSM_TIMEOUT_EN
          // Abandon a hung kernel: reset it and return an all-zero result
          else if (wd_q == WDW'(TO_CYCLES - 1)) begin
            timeout_err_q <= 1'b1;
            k_rst_q       <= 1'b1;
            out_z_q       <= '0;
            out_x_q       <= '0;
            out_valid_q   <= 1'b1;
            state_q       <= S_HOLD;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
`endif
        end
        S_HOLD: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            batch_cnt_q <= batch_cnt_q + 16'd1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign k_rst_o     = k_rst_q;
  assign k_start_o   = k_start_q;
  assign k_a_o       = k_a_q;
  assign k_b_o       = k_b_q;
  assign k_c_o       = k_c_q;
  assign out_valid_o = out_valid_q;
  assign out_z_o     = out_z_q;
  assign out_x_o     = out_x_q;
  assign busy_o      = busy_q;
  assign batch_cnt_o = batch_cnt_q;
`ifdef HLSM_TIMEOUT_EN
  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

endmodule
